// File: rtl/rx_control.sv
// UART receive controller: oversampled start/data/parity/stop FSM.
// Define RX_MAJORITY_SAMPLE_EN for a 2-of-3 majority sample around mid-bit.
module rx_control #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  Parity_EN,
  input  logic                  Parity_type,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_valid,
  output logic                  Parity_error,
  output logic                  Stop_error,
  output logic                  Busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [5:0]            r_p;
  logic [5:0]            r_edge;
  logic [BW-1:0]         r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_ferr;
  logic                  r_dv;
  logic                  r_perr;
  logic                  r_serr;

  logic [5:0] w_half;
  logic       w_last;
  logic       w_sample;
  logic       w_par;

  assign w_half = {1'b0, r_p[5:1]};
  assign w_last = (r_edge == r_p - 6'd1);
  assign w_par  = (^r_shift) ^ Parity_type;

`ifdef RX_MAJORITY_SAMPLE_EN
  logic [2:0] r_win;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_win <= 3'b000;
    end else if (r_state != IDLE &&
                 (r_edge == w_half - 6'd1 ||
                  r_edge == w_half ||
                  r_edge == w_half + 6'd1)) begin
      r_win <= {r_win[1:0], RX_IN};
    end
  end

  assign w_sample = (r_win[0] & r_win[1]) |
                    (r_win[1] & r_win[2]) |
                    (r_win[0] & r_win[2]);
`else
  logic r_smp;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_smp <= 1'b0;
    end else if (r_state != IDLE && r_edge == w_half) begin
      r_smp <= RX_IN;
    end
  end

  assign w_sample = r_smp;
`endif

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_p     <= '0;
      r_edge  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_ferr  <= 1'b0;
      r_dv    <= 1'b0;
      r_perr  <= 1'b0;
      r_serr  <= 1'b0;
    end else begin
      r_dv   <= 1'b0;
      r_perr <= 1'b0;
      r_serr <= 1'b0;
      r_edge <= w_last ? 6'd0 : r_edge + 6'd1;
      case (r_state)
        IDLE: begin
          r_edge <= 6'd0;
          r_bit  <= '0;
          if (!RX_IN) begin
            // The detecting cycle is edge 0 of the start bit.
            r_state <= START;
            r_edge  <= 6'd1;
            r_p     <= Prescale;
            r_ferr  <= 1'b0;
          end
        end
        START: begin
          if (w_last) begin
            r_state <= w_sample ? IDLE : DATA;
          end
        end
        DATA: begin
          if (w_last) begin
            r_shift <= {w_sample, r_shift[DATA_WIDTH-1:1]};
            if (r_bit == LAST_BIT) begin
              r_bit   <= '0;
              r_state <= Parity_EN ? PARITY : STOP;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end
        PARITY: begin
          if (w_last) begin
            if (w_sample != w_par) begin
              r_perr <= 1'b1;
              r_ferr <= 1'b1;
            end
            r_state <= STOP;
          end
        end
        STOP: begin
          if (w_last) begin
            if (!w_sample) begin
              r_serr <= 1'b1;
            end else if (!r_ferr) begin
              r_data <= r_shift;
              r_dv   <= 1'b1;
            end
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_p     <= '0;
          r_edge  <= '0;
          r_bit   <= '0;
          r_shift <= '0;
          r_data  <= '0;
          r_ferr  <= 1'b0;
        end
      endcase
    end
  end

  assign P_DATA       = r_data;
  assign Data_valid   = r_dv;
  assign Parity_error = r_perr;
  assign Stop_error   = r_serr;
  assign Busy         = (r_state == START)  || (r_state == DATA) ||
                        (r_state == PARITY) || (r_state == STOP);

endmodule

// File: tb/tb_rx_control.sv
// Directed bench for rx_control: framing, parity, stop, glitch,
// back-to-back, spike and mid-frame reset cases.
module tb_rx_control;

  logic       CLK;
  logic       Reset;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       Parity_EN;
  logic       Parity_type;
  logic [7:0] P_DATA;
  logic       Data_valid;
  logic       Parity_error;
  logic       Stop_error;
  logic       Busy;

  rx_control #(.DATA_WIDTH(8)) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .RX_IN        (RX_IN),
    .Prescale     (Prescale),
    .Parity_EN    (Parity_EN),
    .Parity_type  (Parity_type),
    .P_DATA       (P_DATA),
    .Data_valid   (Data_valid),
    .Parity_error (Parity_error),
    .Stop_error   (Stop_error),
    .Busy         (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors = 0;
  int errs = 0;
  int cyc = 0;
  int start_cyc = 0;
  int n_dv = 0;
  int n_pe = 0;
  int n_se = 0;
  int dv_cyc[$];
  logic [7:0] dv_data[$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (Reset) begin
      if (Data_valid) begin
        n_dv++;
        dv_cyc.push_back(cyc);
        dv_data.push_back(P_DATA);
      end
      if (Parity_error) n_pe++;
      if (Stop_error) n_se++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_dv = 0;
    n_pe = 0;
    n_se = 0;
    dv_cyc.delete();
    dv_data.delete();
  endtask

  task automatic send_bit(input logic b, input int p);
    RX_IN = b;
    repeat (p) @(negedge CLK);
  endtask

  // Called at a negedge; each bit is held for p rising edges.
  task automatic send_frame(input logic [7:0] d, input int p,
                            input bit pen, input logic pbit,
                            input logic sbit, input int spike);
    Prescale = 6'(p);
    Parity_EN = pen;
    start_cyc = cyc + 1;
    send_bit(1'b0, p);
    Prescale = (p == 16) ? 6'd8 : 6'd16;
    chk("busy_in_frame", 32'(Busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i == spike) begin
        RX_IN = d[i];
        repeat (p / 2) @(negedge CLK);
        RX_IN = ~d[i];
        @(negedge CLK);
        RX_IN = d[i];
        repeat (p / 2 - 1) @(negedge CLK);
      end else begin
        send_bit(d[i], p);
      end
    end
    if (pen) send_bit(pbit, p);
    send_bit(sbit, p);
    RX_IN = 1'b1;
  endtask

  initial begin
    Reset = 1'b0;
    RX_IN = 1'b1;
    Prescale = 6'd8;
    Parity_EN = 1'b0;
    Parity_type = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_pdata", 32'(P_DATA), 32'h0);
    chk("rst_dv", 32'(Data_valid), 32'd0);
    chk("rst_pe", 32'(Parity_error), 32'd0);
    chk("rst_se", 32'(Stop_error), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    Reset = 1'b1;
    repeat (3) @(negedge CLK);

    // 0xA5, P=8, no parity
    clr();
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1);
    repeat (4) @(negedge CLK);
    chk("a5_ndv", 32'(n_dv), 32'd1);
    if (n_dv > 0) begin
      chk("a5_data", 32'(dv_data[0]), 32'hA5);
      chk("a5_latency", 32'(dv_cyc[0] + 1 - start_cyc), 32'd80);
    end
    chk("a5_pdata_hold", 32'(P_DATA), 32'hA5);
    chk("a5_npe", 32'(n_pe), 32'd0);
    chk("a5_nse", 32'(n_se), 32'd0);
    chk("a5_busy_idle", 32'(Busy), 32'd0);

    // 0x3C, P=16, even parity, wrong parity bit 1
    clr();
    Parity_type = 1'b0;
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, -1);
    repeat (4) @(negedge CLK);
    chk("3c_npe", 32'(n_pe), 32'd1);
    chk("3c_ndv", 32'(n_dv), 32'd0);
    chk("3c_nse", 32'(n_se), 32'd0);
    chk("3c_pdata", 32'(P_DATA), 32'hA5);

    // Start glitch: low for 3 edges, P=8
    clr();
    Prescale = 6'd8;
    Parity_EN = 1'b0;
    RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (4) @(negedge CLK);
    chk("glitch_busy_e6", 32'(Busy), 32'd1);
    @(negedge CLK);
    chk("glitch_busy_e7", 32'(Busy), 32'd0);
    repeat (4) @(negedge CLK);
    chk("glitch_pulses", 32'(n_dv + n_pe + n_se), 32'd0);

    // 0xFF, P=32, odd parity (bit 1 correct), stop bit 0
    clr();
    Parity_type = 1'b1;
    send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b0, -1);
    repeat (4) @(negedge CLK);
    chk("ff_nse", 32'(n_se), 32'd1);
    chk("ff_npe", 32'(n_pe), 32'd0);
    chk("ff_ndv", 32'(n_dv), 32'd0);
    chk("ff_pdata", 32'(P_DATA), 32'hA5);

    // Back-to-back 0x01 then 0x80, P=8
    clr();
    Parity_type = 1'b0;
    send_frame(8'h01, 8, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'h80, 8, 1'b0, 1'b0, 1'b1, -1);
    repeat (4) @(negedge CLK);
    chk("b2b_ndv", 32'(n_dv), 32'd2);
    if (n_dv == 2) begin
      chk("b2b_d0", 32'(dv_data[0]), 32'h01);
      chk("b2b_d1", 32'(dv_data[1]), 32'h80);
      chk("b2b_gap", 32'(dv_cyc[1] - dv_cyc[0]), 32'd80);
    end

    // Mid-sample spike on data bit 3 of 0x00
    clr();
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b1, 3);
    repeat (4) @(negedge CLK);
    chk("spike_ndv", 32'(n_dv), 32'd1);
`ifdef RX_MAJORITY_SAMPLE_EN
    chk("spike_pdata", 32'(P_DATA), 32'h00);
`else
    chk("spike_pdata", 32'(P_DATA), 32'h08);
`endif

    // Reset in the middle of a frame
    clr();
    Prescale = 6'd8;
    RX_IN = 1'b0;
    repeat (20) @(negedge CLK);
    Reset = 1'b0;
    #1;
    chk("mrst_busy", 32'(Busy), 32'd0);
    chk("mrst_pdata", 32'(P_DATA), 32'h0);
    RX_IN = 1'b1;
    @(negedge CLK);
    Reset = 1'b1;
    repeat (20) @(negedge CLK);
    chk("mrst_pulses", 32'(n_dv + n_pe + n_se), 32'd0);
    chk("mrst_idle", 32'(Busy), 32'd0);
    send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b1, -1);
    repeat (4) @(negedge CLK);
    chk("mrst_ndv", 32'(n_dv), 32'd1);
    chk("mrst_pdata_new", 32'(P_DATA), 32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
